// File: rtl/packed_struct_rx.sv
// packed_struct_rx: assembles tag/data/checksum byte frames into packed records with delivery and error statistics
module packed_struct_rx #(
  parameter int DATA_BYTES = 1,
  parameter int CNT_W = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_byte_valid,
  input  logic [7:0]              i_byte,
  output logic                    o_byte_ready,
  input  logic                    i_abort,
  output logic                    o_rec_valid,
  input  logic                    i_rec_ready,
  output logic [7:0]              o_rec_tag,
  output logic [DATA_BYTES*8-1:0] o_rec_data,
  output logic                    o_rec_err,
  output logic [CNT_W-1:0]        o_rec_count,
  output logic [CNT_W-1:0]        o_err_count
);
  localparam int W = DATA_BYTES * 8;
  localparam int CW = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
  typedef struct packed {
    logic [7:0]   tag;
    logic [W-1:0] data;
    logic         err;
  } rec_t;
  typedef enum logic [1:0] {S_TAG, S_DATA, S_CHK, S_OUT} state_t;
  state_t state, state_nxt;
  rec_t rec;
  logic [CW-1:0] cnt;
  logic [7:0] acc;
  logic byte_xfer, rec_xfer, flush;
  assign o_byte_ready = (state != S_OUT) && i_rst_n;
  assign byte_xfer = i_byte_valid && o_byte_ready;
  assign rec_xfer = o_rec_valid && i_rec_ready;
  // a committed record in S_OUT cannot be aborted
  assign flush = i_abort && (state != S_OUT);
  assign o_rec_tag = rec.tag;
  assign o_rec_data = rec.data;
  assign o_rec_err = rec.err;
  // state register
  always_ff @(posedge i_clk)
    if (!i_rst_n) state <= S_TAG;
    else state <= state_nxt;
  // frame sequencing: tag, DATA_BYTES data bytes, checksum, then hold until consumed
  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = S_TAG;
    else
      unique case (state)
        S_TAG:  state_nxt = byte_xfer ? S_DATA : S_TAG;
        S_DATA: state_nxt = (byte_xfer && cnt == CW'(DATA_BYTES - 1)) ? S_CHK : S_DATA;
        S_CHK:  state_nxt = byte_xfer ? S_OUT : S_CHK;
        S_OUT:  state_nxt = rec_xfer ? S_TAG : S_OUT;
      endcase
  end
  // record assembly, running checksum and statistics
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rec <= '0;
      cnt <= '0;
      acc <= '0;
      o_rec_valid <= 1'b0;
      o_rec_count <= '0;
      o_err_count <= '0;
    end else begin
      if (flush) begin
        cnt <= '0;
        acc <= '0;
      end else if (byte_xfer && state == S_TAG) begin
        rec.tag <= i_byte;
        acc <= i_byte;
        cnt <= '0;
      end else if (byte_xfer && state == S_DATA) begin
        rec.data <= W'({rec.data, i_byte});
        acc <= acc ^ i_byte;
        cnt <= cnt + 1'b1;
      end else if (byte_xfer && state == S_CHK) begin
        rec.err <= acc != i_byte;
        o_rec_valid <= 1'b1;
      end
      if (rec_xfer) begin
        o_rec_valid <= 1'b0;
        o_rec_count <= o_rec_count + 1'b1;
        if (rec.err && o_err_count != '1) o_err_count <= o_err_count + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_packed_struct_rx.sv
// tb_packed_struct_rx: directed tests of the record receiver with 1- and 4-byte data fields
module tb_packed_struct_rx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bv = 1'b0, ab = 1'b0, rr = 1'b0;
  logic [7:0] bt = '0;
  logic br, rv, err;
  logic [7:0] tag, data, rc, ec;
  logic bv4 = 1'b0, ab4 = 1'b0, rr4 = 1'b0;
  logic [7:0] bt4 = '0;
  logic br4, rv4, err4;
  logic [7:0] tag4, rc4, ec4;
  logic [31:0] data4;
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  packed_struct_rx #(.DATA_BYTES(1), .CNT_W(8)) u1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte_valid(bv), .i_byte(bt), .o_byte_ready(br),
    .i_abort(ab), .o_rec_valid(rv), .i_rec_ready(rr), .o_rec_tag(tag), .o_rec_data(data),
    .o_rec_err(err), .o_rec_count(rc), .o_err_count(ec));

  packed_struct_rx #(.DATA_BYTES(4), .CNT_W(8)) u4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_byte_valid(bv4), .i_byte(bt4), .o_byte_ready(br4),
    .i_abort(ab4), .o_rec_valid(rv4), .i_rec_ready(rr4), .o_rec_tag(tag4), .o_rec_data(data4),
    .o_rec_err(err4), .o_rec_count(rc4), .o_err_count(ec4));

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bv = 1'b1;
    bt = b;
    while (!br && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!br) begin
      errs++;
      $display("FAIL send_timeout byte=%h ready=%b expected 1", b, br);
    end
    @(negedge clk);
    bv = 1'b0;
  endtask

  task automatic send4(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    bv4 = 1'b1;
    bt4 = b;
    while (!br4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!br4) begin
      errs++;
      $display("FAIL send4_timeout byte=%h ready=%b expected 1", b, br4);
    end
    @(negedge clk);
    bv4 = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 7;
    if (rv !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", rv); end
    if (tag !== 8'h00) begin errs++; $display("FAIL reset_tag got=%h exp=00", tag); end
    if (data !== 8'h00) begin errs++; $display("FAIL reset_data got=%h exp=00", data); end
    if (err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", err); end
    if (rc !== 8'd0) begin errs++; $display("FAIL reset_rc got=%0d exp=0", rc); end
    if (ec !== 8'd0) begin errs++; $display("FAIL reset_ec got=%0d exp=0", ec); end
    if (br !== 1'b0) begin errs++; $display("FAIL reset_ready_low got=%b exp=0", br); end
    rst_n = 1'b1;
    #1;
    checks++;
    if (br !== 1'b1) begin errs++; $display("FAIL reset_ready_high got=%b exp=1", br); end
  endtask

  task automatic test_basic;
    rr = 1'b1;
    send(8'hA5);
    send(8'hFF);
    send(8'h5A);
    checks += 5;
    if (rv !== 1'b1) begin errs++; $display("FAIL basic_valid got=%b exp=1", rv); end
    if (tag !== 8'hA5) begin errs++; $display("FAIL basic_tag got=%h exp=a5", tag); end
    if (data !== 8'hFF) begin errs++; $display("FAIL basic_data got=%h exp=ff", data); end
    if (err !== 1'b0) begin errs++; $display("FAIL basic_err got=%b exp=0", err); end
    if (br !== 1'b0) begin errs++; $display("FAIL basic_ready_out got=%b exp=0", br); end
    @(negedge clk);
    checks += 3;
    if (rv !== 1'b0) begin errs++; $display("FAIL basic_valid_drop got=%b exp=0", rv); end
    if (rc !== 8'd1) begin errs++; $display("FAIL basic_rc got=%0d exp=1", rc); end
    if (br !== 1'b1) begin errs++; $display("FAIL basic_ready_back got=%b exp=1", br); end
  endtask

  task automatic test_bad_checksum;
    send(8'h12);
    send(8'h34);
    send(8'h00);
    checks += 4;
    if (rv !== 1'b1) begin errs++; $display("FAIL bad_valid got=%b exp=1", rv); end
    if (err !== 1'b1) begin errs++; $display("FAIL bad_err got=%b exp=1", err); end
    if (tag !== 8'h12) begin errs++; $display("FAIL bad_tag got=%h exp=12", tag); end
    if (data !== 8'h34) begin errs++; $display("FAIL bad_data got=%h exp=34", data); end
    @(negedge clk);
    checks += 2;
    if (ec !== 8'd1) begin errs++; $display("FAIL bad_ec got=%0d exp=1", ec); end
    if (rc !== 8'd2) begin errs++; $display("FAIL bad_rc got=%0d exp=2", rc); end
  endtask

  task automatic test_backpressure;
    rr = 1'b0;
    send(8'h3C);
    send(8'hC3);
    send(8'hFF);
    for (int i = 0; i < 5; i++) begin
      bv = 1'b1;
      bt = 8'h99;
      ab = (i == 2);
      @(negedge clk);
      checks += 5;
      if (br !== 1'b0) begin errs++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", i, br); end
      if (rv !== 1'b1) begin errs++; $display("FAIL bp_valid cyc=%0d got=%b exp=1", i, rv); end
      if (tag !== 8'h3C) begin errs++; $display("FAIL bp_tag cyc=%0d got=%h exp=3c", i, tag); end
      if (data !== 8'hC3) begin errs++; $display("FAIL bp_data cyc=%0d got=%h exp=c3", i, data); end
      if (err !== 1'b0) begin errs++; $display("FAIL bp_err cyc=%0d got=%b exp=0", i, err); end
    end
    ab = 1'b0;
    bv = 1'b0;
    rr = 1'b1;
    @(negedge clk);
    checks += 3;
    if (rv !== 1'b0) begin errs++; $display("FAIL bp_release_valid got=%b exp=0", rv); end
    if (br !== 1'b1) begin errs++; $display("FAIL bp_release_ready got=%b exp=1", br); end
    if (rc !== 8'd3) begin errs++; $display("FAIL bp_rc got=%0d exp=3", rc); end
  endtask

  task automatic test_abort;
    rr4 = 1'b1;
    send4(8'h77);
    send4(8'h11);
    send4(8'h22);
    @(negedge clk);
    bv4 = 1'b1;
    bt4 = 8'hEE;
    ab4 = 1'b1;
    @(negedge clk);
    bv4 = 1'b0;
    ab4 = 1'b0;
    checks += 2;
    if (br4 !== 1'b1) begin errs++; $display("FAIL abort_ready got=%b exp=1", br4); end
    if (rv4 !== 1'b0) begin errs++; $display("FAIL abort_valid got=%b exp=0", rv4); end
    send4(8'h01);
    send4(8'h10);
    send4(8'h20);
    send4(8'h30);
    send4(8'h40);
    send4(8'h41);
    checks += 4;
    if (rv4 !== 1'b1) begin errs++; $display("FAIL abort_frame_valid got=%b exp=1", rv4); end
    if (tag4 !== 8'h01) begin errs++; $display("FAIL abort_frame_tag got=%h exp=01", tag4); end
    if (data4 !== 32'h10203040) begin errs++; $display("FAIL abort_frame_data got=%h exp=10203040", data4); end
    if (err4 !== 1'b0) begin errs++; $display("FAIL abort_frame_err got=%b exp=0", err4); end
    @(negedge clk);
    checks++;
    if (rc4 !== 8'd1) begin errs++; $display("FAIL abort_rc got=%0d exp=1", rc4); end
  endtask

  task automatic test_reset_mid_frame;
    send(8'hAB);
    rst_n = 1'b0;
    @(negedge clk);
    checks += 7;
    if (rv !== 1'b0) begin errs++; $display("FAIL midrst_valid got=%b exp=0", rv); end
    if (tag !== 8'h00) begin errs++; $display("FAIL midrst_tag got=%h exp=00", tag); end
    if (data !== 8'h00) begin errs++; $display("FAIL midrst_data got=%h exp=00", data); end
    if (err !== 1'b0) begin errs++; $display("FAIL midrst_err got=%b exp=0", err); end
    if (rc !== 8'd0) begin errs++; $display("FAIL midrst_rc got=%0d exp=0", rc); end
    if (ec !== 8'd0) begin errs++; $display("FAIL midrst_ec got=%0d exp=0", ec); end
    if (br !== 1'b0) begin errs++; $display("FAIL midrst_ready got=%b exp=0", br); end
    rst_n = 1'b1;
    send(8'h5F);
    send(8'h0F);
    send(8'h50);
    checks += 4;
    if (rv !== 1'b1) begin errs++; $display("FAIL midrst_frame_valid got=%b exp=1", rv); end
    if (tag !== 8'h5F) begin errs++; $display("FAIL midrst_frame_tag got=%h exp=5f", tag); end
    if (data !== 8'h0F) begin errs++; $display("FAIL midrst_frame_data got=%h exp=0f", data); end
    if (err !== 1'b0) begin errs++; $display("FAIL midrst_frame_err got=%b exp=0", err); end
    @(negedge clk);
    checks++;
    if (rc !== 8'd1) begin errs++; $display("FAIL midrst_rc_after got=%0d exp=1", rc); end
  endtask

  task automatic test_counters;
    for (int i = 0; i < 255; i++) begin
      send(8'(i));
      send(8'h00);
      send(8'(i));
    end
    @(negedge clk);
    checks += 2;
    if (rc !== 8'd0) begin errs++; $display("FAIL cnt_rc_wrap got=%0d exp=0", rc); end
    if (ec !== 8'd0) begin errs++; $display("FAIL cnt_ec_clean got=%0d exp=0", ec); end
    for (int i = 0; i < 254; i++) begin
      send(8'h01);
      send(8'h00);
      send(8'h00);
    end
    @(negedge clk);
    checks += 2;
    if (ec !== 8'd254) begin errs++; $display("FAIL cnt_ec_254 got=%0d exp=254", ec); end
    if (rc !== 8'd254) begin errs++; $display("FAIL cnt_rc_254 got=%0d exp=254", rc); end
    for (int i = 0; i < 46; i++) begin
      send(8'h01);
      send(8'h00);
      send(8'h00);
    end
    @(negedge clk);
    checks += 2;
    if (ec !== 8'd255) begin errs++; $display("FAIL cnt_ec_sat got=%0d exp=255", ec); end
    if (rc !== 8'd44) begin errs++; $display("FAIL cnt_rc_44 got=%0d exp=44", rc); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bad_checksum;
    test_backpressure;
    test_abort;
    test_reset_mid_frame;
    test_counters;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
